line_clear_engine: RTL and testbench



---
 rtl/line_clear_if.sv | 29 ++
 rtl/line_clear_engine.sv | 141 ++++++++++++++
 tb/tb_line_clear_engine.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/line_clear_if.sv
// Handshake and row-store port bundle between the lock/scoring logic and line_clear_engine.
interface line_clear_if #(
   parameter int BOARD_WIDTH = 10,
   parameter int CELL_BITS   = 3,
   parameter int ADDR_W      = 5
);
   logic                             start;
   logic                             busy;
   logic                             done;
   logic [4:0]                       lines_cleared;
   logic                             row_rd_en;
   logic [ADDR_W-1:0]                row_rd_addr;
   logic [BOARD_WIDTH*CELL_BITS-1:0] row_rd_data;
   logic                             row_wr_en;
   logic [ADDR_W-1:0]                row_wr_addr;
   logic [BOARD_WIDTH*CELL_BITS-1:0] row_wr_data;

   modport slave (
      input  start, row_rd_data,
      output busy, done, lines_cleared,
             row_rd_en, row_rd_addr, row_wr_en, row_wr_addr, row_wr_data
   );

   modport master (
      output start, row_rd_data,
      input  busy, done, lines_cleared,
             row_rd_en, row_rd_addr, row_wr_en, row_wr_addr, row_wr_data
   );
endinterface

// File: rtl/line_clear_engine.sv
// Post-lock line clear: scans rows bottom-up, drops full rows, compacts survivors
// downward and zero-fills the vacated top rows.
//
//   state  | meaning
//   IDLE   | waiting for start
//   READ   | read strobe for row r
//   EVAL   | row data valid; drop if full, else copy down to row w
//   FILL   | zero one vacated row per cycle, k cycles total
//   DONE   | one-cycle done pulse, lines_cleared published
module line_clear_engine #(
   parameter int BOARD_WIDTH  = 10,
   parameter int BOARD_HEIGHT = 30,
   parameter int CELL_BITS    = 3,
   parameter int ADDR_W       = 5
) (
   input logic         i_clk,
   input logic         i_reset,
   line_clear_if.slave bus
);
   localparam int                ROW_W  = BOARD_WIDTH * CELL_BITS;
   localparam logic [ADDR_W-1:0] BOTTOM = ADDR_W'(BOARD_HEIGHT - 1);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_EVAL, S_FILL, S_DONE} state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_rd_ptr, w_rd_ptr_nxt;
   logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_nxt;
   logic [4:0]        r_k, w_k_nxt;
   logic [4:0]        r_fill_cnt, w_fill_cnt_nxt;
   logic [4:0]        r_lines, w_lines_nxt;

   logic              w_row_full;
   logic              w_rd_en;
   logic [ADDR_W-1:0] w_rd_addr;
   logic              w_wr_en;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [ROW_W-1:0]  w_wr_data;
   logic              w_done;

   always_comb begin
      w_row_full = 1'b1;
      for (int x = 0; x < BOARD_WIDTH; x++) begin
         if (bus.row_rd_data[CELL_BITS*x +: CELL_BITS] == '0) w_row_full = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_k        <= '0;
         r_fill_cnt <= '0;
         r_lines    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rd_ptr   <= w_rd_ptr_nxt;
         r_wr_ptr   <= w_wr_ptr_nxt;
         r_k        <= w_k_nxt;
         r_fill_cnt <= w_fill_cnt_nxt;
         r_lines    <= w_lines_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_rd_ptr_nxt   = r_rd_ptr;
      w_wr_ptr_nxt   = r_wr_ptr;
      w_k_nxt        = r_k;
      w_fill_cnt_nxt = r_fill_cnt;
      w_lines_nxt    = r_lines;
      w_rd_en        = 1'b0;
      w_rd_addr      = '0;
      w_wr_en        = 1'b0;
      w_wr_addr      = '0;
      w_wr_data      = '0;
      w_done         = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_rd_ptr_nxt = BOTTOM;
               w_wr_ptr_nxt = BOTTOM;
               w_k_nxt      = '0;
               w_state_nxt  = S_READ;
            end
         end
         S_READ: begin
            w_rd_en     = 1'b1;
            w_rd_addr   = r_rd_ptr;
            w_state_nxt = S_EVAL;
         end
         S_EVAL: begin
            if (w_row_full) begin
               w_k_nxt = r_k + 5'd1;
            end else begin
               // A survivor below the first cleared row is already in place
               if (r_wr_ptr != r_rd_ptr) begin
                  w_wr_en   = 1'b1;
                  w_wr_addr = r_wr_ptr;
                  w_wr_data = bus.row_rd_data;
               end
               w_wr_ptr_nxt = r_wr_ptr - ADDR_W'(1);
            end
            if (r_rd_ptr != '0) begin
               w_rd_ptr_nxt = r_rd_ptr - ADDR_W'(1);
               w_state_nxt  = S_READ;
            end else if (w_k_nxt != '0) begin
               w_fill_cnt_nxt = w_k_nxt;
               w_state_nxt    = S_FILL;
            end else begin
               w_lines_nxt = w_k_nxt;
               w_state_nxt = S_DONE;
            end
         end
         S_FILL: begin
            w_wr_en        = 1'b1;
            w_wr_addr      = r_wr_ptr;
            w_wr_ptr_nxt   = r_wr_ptr - ADDR_W'(1);
            w_fill_cnt_nxt = r_fill_cnt - 5'd1;
            if (r_fill_cnt == 5'd1) begin
               w_lines_nxt = r_k;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign bus.busy          = (r_state != S_IDLE);
   assign bus.done          = w_done;
   assign bus.lines_cleared = r_lines;
   assign bus.row_rd_en     = w_rd_en;
   assign bus.row_rd_addr   = w_rd_addr;
   assign bus.row_wr_en     = w_wr_en;
   assign bus.row_wr_addr   = w_wr_addr;
   assign bus.row_wr_data   = w_wr_data;
endmodule

// File: tb/tb_line_clear_engine.sv
// Bench for line_clear_engine: row store model, directed boards plus random boards,
// each pass checked against a row-filtering reference of the clear rules.
module tb_line_clear_engine;
   localparam int W  = 10;
   localparam int H  = 30;
   localparam int CB = 3;
   localparam int RW = W * CB;

   typedef logic [RW-1:0] row_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic load = 1'b0;
   row_t mem [H];
   row_t init_board [H];
   int   total = 0;
   int   bad = 0;

   line_clear_if #(.BOARD_WIDTH(W), .CELL_BITS(CB), .ADDR_W(5)) bus ();

   line_clear_engine #(.BOARD_WIDTH(W), .BOARD_HEIGHT(H), .CELL_BITS(CB), .ADDR_W(5)) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (load) mem <= init_board;
      else if (bus.row_wr_en) mem[bus.row_wr_addr] <= bus.row_wr_data;
      if (bus.row_rd_en) bus.row_rd_data <= mem[bus.row_rd_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic row_t full_row();
      row_t r;
      for (int x = 0; x < W; x++) r[CB*x +: CB] = 3'($urandom_range(1, 7));
      return r;
   endfunction

   function automatic row_t part_row();
      row_t r;
      int   z;
      for (int x = 0; x < W; x++) r[CB*x +: CB] = 3'($urandom_range(0, 7));
      z = $urandom_range(0, W - 1);
      r[CB*z +: CB] = '0;
      return r;
   endfunction

   function automatic bit is_full(input row_t r);
      for (int x = 0; x < W; x++) if (r[CB*x +: CB] == '0) return 1'b0;
      return 1'b1;
   endfunction

   // Reference: keep non-full rows in bottom-to-top order, restack them from the bottom.
   task automatic model(input row_t b [H], output row_t e [H], output int k, output int wr);
      row_t keep [$];
      int   lowest_full;
      k = 0;
      lowest_full = -1;
      for (int i = H - 1; i >= 0; i--) begin
         if (is_full(b[i])) begin
            k++;
            if (lowest_full < 0) lowest_full = i;
         end else keep.push_back(b[i]);
      end
      for (int i = 0; i < H; i++) e[i] = '0;
      for (int i = 0; i < keep.size(); i++) e[H - 1 - i] = keep[i];
      wr = k;
      for (int i = 0; i < lowest_full; i++) if (!is_full(b[i])) wr++;
   endtask

   task automatic load_board(input row_t b [H]);
      init_board = b;
      @(negedge clk) load = 1'b1;
      @(negedge clk) load = 1'b0;
   endtask

   task automatic run_pass(input string name, input int spur_at, input int rst_at);
      row_t exp_b [H];
      int   k, exp_wr, cyc, reads, writes, overlap, idle_busy, done_cyc;
      bit   aborted;
      model(mem, exp_b, k, exp_wr);
      reads = 0; writes = 0; overlap = 0; idle_busy = 0; done_cyc = -1; aborted = 0;
      @(negedge clk);
      bus.start = 1'b1;
      cyc = 0;
      while (cyc < 200 && done_cyc < 0 && !aborted) begin
         @(negedge clk);
         cyc++;
         bus.start = (cyc == spur_at);
         if (cyc == rst_at) begin
            rst = 1'b1;
            #1;
            check({name, " rst busy"}, 32'(bus.busy), 0);
            check({name, " rst rd_en"}, 32'(bus.row_rd_en), 0);
            check({name, " rst wr_en"}, 32'(bus.row_wr_en), 0);
            check({name, " rst done"}, 32'(bus.done), 0);
            @(negedge clk);
            check({name, " rst idle"}, 32'(bus.busy), 0);
            rst = 1'b0;
            aborted = 1;
         end else begin
            if (bus.row_rd_en) reads++;
            if (bus.row_wr_en) writes++;
            if (bus.row_rd_en && bus.row_wr_en) overlap++;
            if (!bus.busy) idle_busy++;
            if (bus.done) done_cyc = cyc;
         end
      end
      if (aborted) return;
      check({name, " done_cycle"}, 32'(done_cyc), 32'(2 * H + 1 + k));
      @(negedge clk);
      check({name, " done_pulse"}, 32'(bus.done), 0);
      check({name, " busy_after"}, 32'(bus.busy), 0);
      check({name, " lines"}, 32'(bus.lines_cleared), 32'(k));
      check({name, " reads"}, 32'(reads), 32'(H));
      check({name, " writes"}, 32'(writes), 32'(exp_wr));
      check({name, " rd_wr_overlap"}, 32'(overlap), 0);
      check({name, " busy_gap"}, 32'(idle_busy), 0);
      for (int i = 0; i < H; i++) check($sformatf("%s row%0d", name, i), 32'(mem[i]), 32'(exp_b[i]));
      repeat (3) @(negedge clk);
      check({name, " no_requeue"}, 32'(bus.busy), 0);
      check({name, " lines_hold"}, 32'(bus.lines_cleared), 32'(k));
   endtask

   initial begin
      row_t b [H];
      row_t pat_a, pat_b, r;
      pat_a = row_t'(5);
      pat_b = row_t'((2 << 9) | (6 << 21));
      bus.start = 1'b0;

      repeat (2) @(negedge clk);
      check("reset busy", 32'(bus.busy), 0);
      check("reset done", 32'(bus.done), 0);
      check("reset rd_en", 32'(bus.row_rd_en), 0);
      check("reset wr_en", 32'(bus.row_wr_en), 0);
      check("reset lines", 32'(bus.lines_cleared), 0);
      check("reset rd_addr", 32'(bus.row_rd_addr), 0);
      check("reset wr_addr", 32'(bus.row_wr_addr), 0);
      check("reset wr_data", 32'(bus.row_wr_data), 0);
      rst = 1'b0;

      for (int i = 0; i < H; i++) b[i] = '0;
      load_board(b);
      run_pass("empty", -1, -1);

      b[29] = full_row(); b[28] = pat_a;
      load_board(b);
      run_pass("single", -1, -1);

      for (int i = 0; i < H; i++) b[i] = '0;
      for (int i = 26; i < 30; i++) b[i] = full_row();
      b[25] = pat_b;
      load_board(b);
      run_pass("tetris", -1, -1);

      for (int i = 0; i < H; i++) b[i] = '0;
      b[29] = full_row(); b[28] = pat_a; b[27] = full_row(); b[26] = pat_b;
      load_board(b);
      run_pass("split", -1, -1);

      for (int i = 0; i < H; i++) b[i] = '0;
      r = full_row();
      r[27 +: 3] = '0;
      b[29] = r;
      load_board(b);
      run_pass("nearly", -1, -1);

      for (int i = 0; i < H; i++) b[i] = '0;
      load_board(b);
      run_pass("spur_start", 10, -1);

      b[29] = full_row(); b[28] = pat_a; b[27] = full_row(); b[20] = pat_b;
      load_board(b);
      run_pass("mid_reset", -1, 20);
      run_pass("after_reset", -1, -1);

      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < H; i++) begin
            case ($urandom_range(0, 3))
               0, 1: b[i] = full_row();
               2: b[i] = part_row();
               default: b[i] = '0;
            endcase
         end
         load_board(b);
         run_pass($sformatf("rand%0d", t), (t == 3) ? 40 : -1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
